// File: rtl/ppu_pkg.sv
// Shared PPU constants, the per-slot sprite state record and a bit-reverse helper.
package ppu_pkg;

  localparam int unsigned VIS_W       = 256;
  localparam int unsigned FETCH_START = 256;
  localparam int unsigned FETCH_END   = 319;
  localparam int unsigned VIS_LINES   = 240;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] attr;
    logic [7:0] lo;
    logic [7:0] hi;
    logic       spr0;
  } spr_slot_t;

  // Mirrors a pattern byte for horizontally flipped sprites.
  function automatic logic [7:0] bit_rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

endpackage

// File: rtl/ppu_spr_compose_if.sv
// Sprite slot-load bus driven by the sprite evaluation/fetch logic.
interface ppu_spr_compose_if #(
  parameter int unsigned SLOT_W = 3
);
  logic              ld_valid;
  logic [SLOT_W-1:0] ld_slot;
  logic [7:0]        ld_x;
  logic [7:0]        ld_attr;
  logic [7:0]        ld_pat_lo;
  logic [7:0]        ld_pat_hi;
  logic              ld_spr0;

  modport master (output ld_valid, ld_slot, ld_x, ld_attr, ld_pat_lo, ld_pat_hi, ld_spr0);
  modport slave  (input  ld_valid, ld_slot, ld_x, ld_attr, ld_pat_lo, ld_pat_hi, ld_spr0);
endinterface

// File: rtl/ppu_spr_slot.sv
// One sprite slot: x down-counter followed by two pattern shift registers.
module ppu_spr_slot
  import ppu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       clear,
  input  logic       active,
  input  spr_slot_t  ld_data,
  output logic       opaque_c,
  output logic [3:0] pix_c,
  output logic       behind_c,
  output logic       spr0_c
);

  spr_slot_t slot;
  logic      shown_c;
  logic      unused_attr;

  always_ff @(posedge clk) begin
    if (reset) begin
      slot <= '0;
    end else if (load) begin
      slot <= ld_data;
    end else if (clear) begin
      slot.lo <= 8'h00;
      slot.hi <= 8'h00;
    end else if (active) begin
      if (slot.x != 8'd0) begin
        slot.x <= slot.x - 8'd1;
      end else begin
        slot.lo <= {slot.lo[6:0], 1'b0};
        slot.hi <= {slot.hi[6:0], 1'b0};
      end
    end
  end

  // The slot drives a pixel only once its counter has run out.
  always_comb begin
    shown_c  = active && (slot.x == 8'd0);
    pix_c    = {slot.attr[1:0], slot.hi[7], slot.lo[7]};
    opaque_c = shown_c && (slot.hi[7] || slot.lo[7]);
    behind_c = slot.attr[5];
    spr0_c   = slot.spr0;
  end

  assign unused_attr = ^{slot.attr[7:6], slot.attr[4:2]};

endmodule

// File: rtl/ppu_spr_compose.sv
// Sprite slot array, priority select and sprite/background pixel composition.
module ppu_spr_compose
  import ppu_pkg::*;
#(
  parameter int unsigned NUM_SPR = 8,
  parameter int unsigned SLOT_W  = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [9:0]          x_idx,
  input  logic [9:0]          scanline,
  input  logic                render_en,
  input  logic                show_bg_left,
  input  logic                show_spr_left,
  input  logic [3:0]          bg_pixel,
  ppu_spr_compose_if.slave    ld,
  input  logic                spr0_clr,
  output logic [4:0]          pixel,
  output logic                pixel_valid,
  output logic                spr0_hit
);

  logic        visible_c, active_c, ld_ok_c, clear_c, left_c;
  spr_slot_t   ld_data_c;

  logic [NUM_SPR-1:0] opq, behind, s0f;
  logic [3:0]         spix [NUM_SPR];

  logic       spr_opq_c, spr_behind_c, spr_vis_c, bg_vis_c, spr0_any_c, hit_c;
  logic [3:0] spr_pix_c;
  logic [4:0] pixel_c;

  // Dot classification and load gating; flip is applied once before fan-out.
  always_comb begin
    visible_c = (scanline < 10'(VIS_LINES)) && (x_idx < 10'(VIS_W));
    active_c  = visible_c && render_en;
    clear_c   = (x_idx == 10'(FETCH_START));
    ld_ok_c   = ld.ld_valid && (x_idx >= 10'(FETCH_START)) && (x_idx <= 10'(FETCH_END))
                && (32'(ld.ld_slot) < NUM_SPR);
    ld_data_c.x    = ld.ld_x;
    ld_data_c.attr = ld.ld_attr;
    ld_data_c.lo   = ld.ld_attr[6] ? bit_rev8(ld.ld_pat_lo) : ld.ld_pat_lo;
    ld_data_c.hi   = ld.ld_attr[6] ? bit_rev8(ld.ld_pat_hi) : ld.ld_pat_hi;
    ld_data_c.spr0 = ld.ld_spr0;
  end

  for (genvar i = 0; i < NUM_SPR; i++) begin : g_slot
    ppu_spr_slot u_slot (
      .clk      (clk),
      .reset    (reset),
      .load     (ld_ok_c && (ld.ld_slot == SLOT_W'(i))),
      .clear    (clear_c),
      .active   (active_c),
      .ld_data  (ld_data_c),
      .opaque_c (opq[i]),
      .pix_c    (spix[i]),
      .behind_c (behind[i]),
      .spr0_c   (s0f[i])
    );
  end

  // Lowest-index opaque slot wins; left-edge masks apply after selection.
  always_comb begin
    spr_opq_c    = 1'b0;
    spr_pix_c    = 4'h0;
    spr_behind_c = 1'b0;
    for (int i = int'(NUM_SPR) - 1; i >= 0; i--) begin
      if (opq[SLOT_W'(i)]) begin
        spr_opq_c    = 1'b1;
        spr_pix_c    = spix[SLOT_W'(i)];
        spr_behind_c = behind[SLOT_W'(i)];
      end
    end
    left_c     = (x_idx < 10'd8);
    spr_vis_c  = spr_opq_c && !(left_c && !show_spr_left);
    spr0_any_c = (|(opq & s0f)) && !(left_c && !show_spr_left);
    bg_vis_c   = render_en && (bg_pixel[1:0] != 2'b00) && !(left_c && !show_bg_left);
    hit_c      = spr0_any_c && bg_vis_c && (x_idx != 10'd255);

    pixel_c = 5'h00;
    if (render_en) begin
      if (spr_vis_c && !(bg_vis_c && spr_behind_c)) pixel_c = {1'b1, spr_pix_c};
      else if (bg_vis_c)                            pixel_c = {1'b0, bg_pixel};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pixel       <= 5'h00;
      pixel_valid <= 1'b0;
      spr0_hit    <= 1'b0;
    end else begin
      pixel       <= pixel_c;
      pixel_valid <= visible_c;
      if (spr0_clr)   spr0_hit <= 1'b0;
      else if (hit_c) spr0_hit <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ppu_spr_compose.sv
// Directed scoreboard bench for ppu_spr_compose: loads, priority, flip, masks, hit, reset.
module tb_ppu_spr_compose;

  localparam int unsigned NSPR = 8;
  localparam int unsigned SW   = 3;

  typedef struct {
    string      tag;
    int         x;
    logic [6:0] exp;
  } sb_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] x_idx, scanline;
  logic       render_en, show_bg_left, show_spr_left, spr0_clr;
  logic [3:0] bg_pixel;
  logic [4:0] pixel;
  logic       pixel_valid, spr0_hit;

  ppu_spr_compose_if #(.SLOT_W(SW)) ld_bus ();

  ppu_spr_compose #(.NUM_SPR(NSPR), .SLOT_W(SW)) dut (
    .clk           (clk),
    .reset         (reset),
    .x_idx         (x_idx),
    .scanline      (scanline),
    .render_en     (render_en),
    .show_bg_left  (show_bg_left),
    .show_spr_left (show_spr_left),
    .bg_pixel      (bg_pixel),
    .ld            (ld_bus),
    .spr0_clr      (spr0_clr),
    .pixel         (pixel),
    .pixel_valid   (pixel_valid),
    .spr0_hit      (spr0_hit)
  );

  always #5 clk = ~clk;

  sb_t  sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic exp_hit = 1'b0;

  // Push the expectation for the dot currently driven, clock it, then check.
  task automatic tick(input string tag, input logic v, input logic [4:0] p);
    sb_t e;
    sb.push_back('{tag: tag, x: int'(x_idx), exp: {v, p, exp_hit}});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_cmp++;
    assert ({pixel_valid, pixel, spr0_hit} === e.exp)
    else begin
      n_bad++;
      $error("FAIL %s x=%0d observed={valid,pixel,hit}=%h expected=%h",
             e.tag, e.x, {pixel_valid, pixel, spr0_hit}, e.exp);
    end
  endtask

  task automatic clear_step();
    x_idx    = 10'd256;
    bg_pixel = 4'h0;
    tick("clr256", 1'b0, 5'h00);
  endtask

  task automatic load_slot(input int slot, input logic [7:0] lx, input logic [7:0] attr,
                           input logic [7:0] lo, input logic [7:0] hi, input logic s0);
    x_idx            = 10'(257 + slot);
    bg_pixel         = 4'h0;
    ld_bus.ld_valid  = 1'b1;
    ld_bus.ld_slot   = SW'(slot);
    ld_bus.ld_x      = lx;
    ld_bus.ld_attr   = attr;
    ld_bus.ld_pat_lo = lo;
    ld_bus.ld_pat_hi = hi;
    ld_bus.ld_spr0   = s0;
    tick("load", 1'b0, 5'h00);
    ld_bus.ld_valid  = 1'b0;
  endtask

  // Run dots x0..x1 of a line; hot_x gets hot_pix, other dots show bg; hit_x sets the hit.
  task automatic run(input string tag, input int line, input int x0, input int x1,
                     input logic [3:0] bg, input int hot_x, input logic [4:0] hot_pix,
                     input int hit_x);
    logic [4:0] e;
    for (int x = x0; x <= x1; x++) begin
      scanline = 10'(line);
      x_idx    = 10'(x);
      bg_pixel = bg;
      e = (bg[1:0] != 2'b00) ? {1'b0, bg} : 5'h00;
      if (x == hot_x) e = hot_pix;
      if (x == hit_x) exp_hit = 1'b1;
      tick(tag, (line < 240) && (x < 256), e);
    end
  endtask

  initial begin
    reset = 1'b1; render_en = 1'b1; show_bg_left = 1'b1; show_spr_left = 1'b1;
    spr0_clr = 1'b0; scanline = 10'd5; x_idx = 10'd10; bg_pixel = 4'h1;
    ld_bus.ld_valid = 1'b0; ld_bus.ld_slot = '0; ld_bus.ld_x = '0; ld_bus.ld_attr = '0;
    ld_bus.ld_pat_lo = '0; ld_bus.ld_pat_hi = '0; ld_bus.ld_spr0 = 1'b0;

    tick("reset0", 1'b0, 5'h00);
    tick("reset1", 1'b0, 5'h00);
    reset = 1'b0;

    // Single sprite at x=10 over transparent background.
    scanline = 10'd4;
    clear_step();
    load_slot(0, 8'd10, 8'h00, 8'h80, 8'h00, 1'b0);
    run("single", 5, 0, 255, 4'h0, 10, 5'h11, -1);

    // Slot0 behind an opaque bg wins over slot1 in front.
    clear_step();
    load_slot(0, 8'd20, 8'h20, 8'h80, 8'h00, 1'b0);
    load_slot(1, 8'd20, 8'h00, 8'h80, 8'h80, 1'b0);
    run("prio", 6, 0, 31, 4'h3, -1, 5'h00, -1);

    // Horizontal flip: lo=01 becomes opaque at the first dot.
    clear_step();
    load_slot(0, 8'd0, 8'h40, 8'h01, 8'h00, 1'b0);
    run("flip", 8, 0, 7, 4'h0, 0, 5'h11, -1);

    // Sprite-0 masked in the left 8 dots: no hit.
    clear_step();
    load_slot(0, 8'd4, 8'h00, 8'hF0, 8'h00, 1'b1);
    show_spr_left = 1'b0;
    run("s0left", 9, 0, 15, 4'h1, -1, 5'h00, -1);
    show_spr_left = 1'b1;

    // Sprite-0 at x=255: visible but no hit.
    clear_step();
    load_slot(0, 8'd255, 8'h00, 8'h80, 8'h00, 1'b1);
    run("s0x255", 10, 0, 255, 4'h1, 255, 5'h11, -1);

    // Sprite-0 at x=100: hit sets and holds until cleared.
    clear_step();
    load_slot(0, 8'd100, 8'h00, 8'h80, 8'h00, 1'b1);
    run("s0hit", 11, 0, 110, 4'h1, 100, 5'h11, 100);
    clear_step();
    x_idx = 10'd300; spr0_clr = 1'b1; exp_hit = 1'b0;
    tick("s0clr", 1'b0, 5'h00);
    spr0_clr = 1'b0;

    // Set condition coinciding with clear: clear wins.
    clear_step();
    load_slot(0, 8'd50, 8'h00, 8'h80, 8'h00, 1'b1);
    run("s0both", 12, 0, 49, 4'h1, -1, 5'h00, -1);
    spr0_clr = 1'b1;
    run("s0both", 12, 50, 50, 4'h1, 50, 5'h11, -1);
    spr0_clr = 1'b0;
    run("s0both", 12, 51, 60, 4'h1, -1, 5'h00, -1);

    // Load strobe during the visible part of the line is ignored.
    clear_step();
    run("ldign", 13, 0, 99, 4'h0, -1, 5'h00, -1);
    ld_bus.ld_valid = 1'b1; ld_bus.ld_slot = '0; ld_bus.ld_x = 8'd5;
    ld_bus.ld_attr = 8'h00; ld_bus.ld_pat_lo = 8'hFF; ld_bus.ld_pat_hi = 8'hFF;
    run("ldign", 13, 100, 100, 4'h0, -1, 5'h00, -1);
    ld_bus.ld_valid = 1'b0;
    run("ldign", 13, 101, 130, 4'h0, -1, 5'h00, -1);

    // Reset mid-line wipes the pending sprite for the rest of the line.
    clear_step();
    load_slot(0, 8'd60, 8'h00, 8'hFF, 8'h00, 1'b0);
    run("rstmid", 14, 0, 49, 4'h0, -1, 5'h00, -1);
    reset = 1'b1; x_idx = 10'd50;
    tick("rstmid", 1'b0, 5'h00);
    reset = 1'b0;
    run("rstmid", 14, 51, 255, 4'h0, -1, 5'h00, -1);

    // Rendering off: pixel zero and the counter holds until re-enabled.
    clear_step();
    load_slot(0, 8'd3, 8'h00, 8'h80, 8'h00, 1'b0);
    render_en = 1'b0;
    for (int x = 0; x <= 9; x++) begin
      scanline = 10'd15; x_idx = 10'(x); bg_pixel = 4'h1;
      tick("rdoff", 1'b1, 5'h00);
    end
    render_en = 1'b1;
    run("rdon", 15, 10, 20, 4'h1, 13, 5'h11, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
